// File: rtl/ysyx_22040386_fetch_queue.sv
// Multi-cycle instruction fetch with a DEPTH-entry prefetch queue and redirect flush.
// Define YSYX_22040386_FETCH_PERF_EN to add the perf_fetch_cnt / perf_stall_cnt counters.
//
// state | meaning
// REQ   | may issue a request while the queue has room
// WAIT  | one request outstanding, response will be queued
// DROP  | one request outstanding, response will be discarded
module ysyx_22040386_fetch_queue #(
    parameter int          XLEN     = 64,
    parameter int          BUS_W    = 64,
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic             clk,
    input  logic             rst,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [XLEN-1:0]  req_addr,
    input  logic             rsp_valid,
    input  logic [BUS_W-1:0] rsp_data,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [31:0]      inst,
    output logic [XLEN-1:0]  inst_pc
`ifdef YSYX_22040386_FETCH_PERF_EN
    ,
    output logic [63:0]      perf_fetch_cnt,
    output logic [63:0]      perf_stall_cnt
`endif
);

    localparam int OFF = $clog2(BUS_W / 8);
    localparam int AW  = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t          state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] q_pc   [DEPTH];
    logic [31:0]     q_inst [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;

    logic            empty;
    logic            full;
    logic            req_fire;
    logic            push;
    logic            pop;
    logic [OFF-1:0]  word_sel;
    logic [31:0]     rsp_word;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // rst gates the request so nothing is issued while the block is held in reset.
    assign req_valid = (state == S_REQ) && !full && !rst;
    assign req_addr  = {fetch_pc[XLEN-1:OFF], {OFF{1'b0}}};
    assign req_fire  = req_valid && req_ready;

    assign word_sel = fetch_pc[OFF-1:0] >> 2;
    assign rsp_word = rsp_data[32*word_sel +: 32];

    assign push = (state == S_WAIT) && rsp_valid && !redirect_valid;
    assign inst_valid = !empty && !redirect_valid;
    assign pop  = inst_valid && inst_ready;

    assign inst    = q_inst[rd_ptr[AW-1:0]];
    assign inst_pc = q_pc[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_REQ;
            fetch_pc <= RESET_PC[XLEN-1:0];
        end else begin
            case (state)
                S_REQ: begin
                    if (req_fire)
                        state <= redirect_valid ? S_DROP : S_WAIT;
                end
                S_WAIT: begin
                    if (rsp_valid)
                        state <= S_REQ;
                    else if (redirect_valid)
                        state <= S_DROP;
                end
                S_DROP: begin
                    if (rsp_valid)
                        state <= S_REQ;
                end
                default: state <= S_REQ;
            endcase

            if (redirect_valid)
                fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            else if (push)
                fetch_pc <= fetch_pc + XLEN'(4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_pc[i]   <= '0;
                q_inst[i] <= '0;
            end
        end else if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                q_pc[wr_ptr[AW-1:0]]   <= fetch_pc;
                q_inst[wr_ptr[AW-1:0]] <= rsp_word;
                wr_ptr                 <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

`ifdef YSYX_22040386_FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (push)
                perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
            if (inst_ready && !inst_valid)
                perf_stall_cnt <= perf_stall_cnt + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_22040386_fetch_queue.sv
// Directed bench for ysyx_22040386_fetch_queue: a cycle table for sequential fetch,
// then hand-written sequences for backpressure, redirects and the full-queue flush.
module tb_ysyx_22040386_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        rsp_valid;
    logic [63:0] rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
`ifdef YSYX_22040386_FETCH_PERF_EN
    logic [63:0] perf_fetch_cnt;
    logic [63:0] perf_stall_cnt;
`endif

    ysyx_22040386_fetch_queue dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc)
`ifdef YSYX_22040386_FETCH_PERF_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rr;
        logic        rv;
        logic [63:0] rd;
        logic        ir;
        logic        e_rv;
        logic [63:0] e_addr;
        logic        e_iv;
        logic [31:0] e_inst;
        logic [63:0] e_pc;
    } vec_t;

    vec_t vecs [8];

    int tests  = 0;
    int failed = 0;

    // memory model and scoreboard state
    int          mem_lat;
    bit          pend;
    int          lat_cnt;
    logic [63:0] paddr;
    int          hs_cnt;
    logic [63:0] last_hs;
    int          vcnt;
    int          pops;
    logic [63:0] exp_pc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] f(input logic [63:0] p);
        return p[31:0] ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [63:0] mem(input logic [63:0] a);
        return {f(a + 64'd4), f(a)};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        pend = 1'b0; lat_cnt = 0; exp_pc = 64'h8000_0000;
        @(negedge clk);
        #2;
        chk("rst_req_valid", {63'd0, req_valid}, 64'd0);
        chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
        chk("rst_inst", {32'd0, inst}, 64'd0);
        chk("rst_inst_pc", inst_pc, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // One clock cycle with the auto-responding memory; caller sets inst_ready/redirect.
    task automatic step();
        logic        hs;
        logic [63:0] hs_addr;
        if (pend && lat_cnt == 0) begin
            rsp_valid = 1'b1;
            rsp_data  = mem(paddr);
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = '0;
        end
        #2;
        hs      = req_valid && req_ready;
        hs_addr = req_addr;
        if (redirect_valid)
            chk("redir_inst_valid", {63'd0, inst_valid}, 64'd0);
        if (inst_valid)
            vcnt++;
        if (inst_valid && inst_ready) begin
            chk("pop_pc", inst_pc, exp_pc);
            chk("pop_inst", {32'd0, inst}, {32'd0, f(exp_pc)});
            exp_pc += 64'd4;
            pops++;
        end
        if (redirect_valid)
            exp_pc = {redirect_pc[63:2], 2'b00};
        @(posedge clk);
        if (rsp_valid)
            pend = 1'b0;
        else if (pend)
            lat_cnt--;
        if (hs) begin
            pend    = 1'b1;
            paddr   = hs_addr;
            lat_cnt = mem_lat - 1;
            hs_cnt++;
            last_hs = hs_addr;
        end
        @(negedge clk);
    endtask

    initial begin
        int h0, p0, v0, n;

        vecs[0] = '{1'b1, 1'b0, 64'd0,                  1'b0, 1'b1, 64'h8000_0000, 1'b0, 32'd0,          64'd0};
        vecs[1] = '{1'b1, 1'b1, 64'hA1A1_0004_A0A0_0000, 1'b0, 1'b0, 64'h8000_0000, 1'b0, 32'd0,          64'd0};
        vecs[2] = '{1'b1, 1'b0, 64'd0,                  1'b0, 1'b1, 64'h8000_0000, 1'b1, 32'hA0A0_0000, 64'h8000_0000};
        vecs[3] = '{1'b1, 1'b1, 64'hB1B1_0000_B0B0_0000, 1'b0, 1'b0, 64'h8000_0000, 1'b1, 32'hA0A0_0000, 64'h8000_0000};
        vecs[4] = '{1'b1, 1'b0, 64'd0,                  1'b1, 1'b1, 64'h8000_0008, 1'b1, 32'hA0A0_0000, 64'h8000_0000};
        vecs[5] = '{1'b1, 1'b1, 64'hC1C1_0000_C0C0_0000, 1'b1, 1'b0, 64'h8000_0008, 1'b1, 32'hB1B1_0000, 64'h8000_0004};
        vecs[6] = '{1'b0, 1'b0, 64'd0,                  1'b1, 1'b1, 64'h8000_0008, 1'b1, 32'hC0C0_0000, 64'h8000_0008};
        vecs[7] = '{1'b0, 1'b0, 64'd0,                  1'b0, 1'b1, 64'h8000_0008, 1'b0, 32'd0,          64'd0};

        mem_lat = 1; hs_cnt = 0; vcnt = 0; pops = 0; last_hs = '0; paddr = '0;

        // sequential fetch, table driven
        do_reset();
        for (int i = 0; i < 8; i++) begin
            req_ready  = vecs[i].rr;
            rsp_valid  = vecs[i].rv;
            rsp_data   = vecs[i].rd;
            inst_ready = vecs[i].ir;
            #2;
            chk($sformatf("v%0d_req_valid", i), {63'd0, req_valid}, {63'd0, vecs[i].e_rv});
            chk($sformatf("v%0d_req_addr", i), req_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_inst_valid", i), {63'd0, inst_valid}, {63'd0, vecs[i].e_iv});
            if (vecs[i].e_iv) begin
                chk($sformatf("v%0d_inst", i), {32'd0, inst}, {32'd0, vecs[i].e_inst});
                chk($sformatf("v%0d_inst_pc", i), inst_pc, vecs[i].e_pc);
            end
            @(negedge clk);
        end

        // decoder stalled: exactly DEPTH requests, then drain in order
        do_reset();
        req_ready = 1'b1; mem_lat = 1;
        h0 = hs_cnt;
        for (int i = 0; i < 20; i++) step();
        chk("stall_req_count", 64'(hs_cnt - h0), 64'd4);
        #1;
        chk("stall_req_valid", {63'd0, req_valid}, 64'd0);
        inst_ready = 1'b1;
        p0 = pops;
        for (int i = 0; i < 12; i++) step();
        chk("drain_pops", {63'd0, (pops - p0) >= 4}, 64'd1);
        chk("drain_resume", {63'd0, (hs_cnt - h0) > 4}, 64'd1);

        // redirect while WAIT
        do_reset();
        req_ready = 1'b1; inst_ready = 1'b1; mem_lat = 2;
        step();
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0102;
        step();
        redirect_valid = 1'b0;
        h0 = hs_cnt; n = 0;
        while (hs_cnt == h0 && n < 20) begin step(); n++; end
        chk("wait_redir_hs_seen", {63'd0, hs_cnt > h0}, 64'd1);
        chk("wait_redir_addr", last_hs, 64'h8000_0100);
        p0 = pops; n = 0;
        while (pops == p0 && n < 20) begin step(); n++; end
        chk("wait_redir_pop_seen", {63'd0, pops > p0}, 64'd1);

        // redirect in the handshake cycle, response 3 cycles later
        do_reset();
        req_ready = 1'b1; inst_ready = 1'b1; mem_lat = 3;
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
        h0 = hs_cnt;
        step();
        redirect_valid = 1'b0;
        chk("hs_redir_issued", 64'(hs_cnt - h0), 64'd1);
        h0 = hs_cnt; v0 = vcnt; n = 0;
        while (hs_cnt == h0 && n < 20) begin step(); n++; end
        chk("hs_redir_hs_seen", {63'd0, hs_cnt > h0}, 64'd1);
        chk("hs_redir_addr", last_hs, 64'h8000_0200);
        chk("hs_redir_no_valid", 64'(vcnt - v0), 64'd0);
        p0 = pops; n = 0;
        while (pops == p0 && n < 20) begin step(); n++; end
        chk("hs_redir_pop_seen", {63'd0, pops > p0}, 64'd1);

        // redirect with a full queue and the decoder ready
        do_reset();
        req_ready = 1'b1; mem_lat = 1;
        for (int i = 0; i < 12; i++) step();
        #1;
        chk("full_req_valid", {63'd0, req_valid}, 64'd0);
        chk("full_inst_valid", {63'd0, inst_valid}, 64'd1);
        inst_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0300;
        p0 = pops;
        step();
        redirect_valid = 1'b0;
        chk("full_redir_no_pop", 64'(pops - p0), 64'd0);
        #1;
        chk("full_flush_inst_valid", {63'd0, inst_valid}, 64'd0);
        step();
`ifdef YSYX_22040386_FETCH_PERF_EN
        chk("perf_fetch_cnt", perf_fetch_cnt, 64'd4);
        chk("perf_stall_cnt", perf_stall_cnt, 64'd2);
`endif
        p0 = pops; n = 0;
        while (pops == p0 && n < 20) begin step(); n++; end
        chk("full_redir_pop_seen", {63'd0, pops > p0}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/ysyx_22040386_fetch_queue.md
# ysyx_22040386_fetch_queue

Multi-cycle instruction fetch unit with a parametrised prefetch queue. It replaces the combinational, zero-latency instruction read with a valid/ready memory request/response handshake. Redirects from branch/jump resolution are applied by discarding stale responses and flushing the queue. It sits between the PC/branch logic and the decoder, and feeds the decoder one 32-bit instruction per handshake.

## Interface
Parameters:
- XLEN, 64, width of PC and memory address
- BUS_W, 64, memory read data width; power of two, at least 32
- DEPTH, 4, prefetch queue entries; power of two, at least 2
- RESET_PC, 64'h8000_0000, first fetch address after reset

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  out  1  memory read request valid
- req_ready  in  1  memory accepts the request
- req_addr  out  XLEN  fetch PC with low log2(BUS_W/8) bits cleared
- rsp_valid  in  1  read data valid; no backpressure
- rsp_data  in  BUS_W  read data for the last accepted request
- redirect_valid  in  1  taken branch/jump; flush and refetch
- redirect_pc  in  XLEN  new PC; bits [1:0] ignored (treated as 0)
- inst_valid  out  1  queue head valid
- inst_ready  in  1  decoder consumes the head
- inst  out  32  head instruction
- inst_pc  out  XLEN  PC of the head instruction

## Operation
- Registers: fetch_pc, state, queue of DEPTH entries {pc, inst}, rd/wr pointers of log2(DEPTH)+1 bits (full/empty from the MSB compare).
- States:
  - REQ: `req_valid = (count < DEPTH)`.
  - WAIT: one request is outstanding.
  - DROP: one outstanding response will be discarded.
- REQ → WAIT on a req handshake. WAIT → REQ on rsp_valid. DROP → REQ on rsp_valid.
- At most one request is outstanding. rsp_valid is only sampled in WAIT and DROP. The memory must not respond in the handshake cycle.
- In WAIT on rsp_valid:
  - push {fetch_pc, rsp_data[32*k +: 32]}, with k = fetch_pc[log2(BUS_W/8)-1:2];
  - fetch_pc += 4, wrapping mod 2^XLEN.
- Redirect (highest priority):
  - fetch_pc ← {redirect_pc[XLEN-1:2], 2'b00} and the queue is emptied next cycle.
  - inst_valid is forced to 0 in the redirect cycle, so no pop happens.
  - REQ without handshake: stays in REQ. req_addr may change; the memory samples the address only at handshake.
  - REQ with handshake in the same cycle: goes to DROP.
  - WAIT: goes to DROP, unless rsp_valid is also high in that cycle, in which case the response is discarded and the state goes to REQ.
  - DROP: stays in DROP, unless rsp_valid is also high, in which case it goes to REQ.
- Push and pop in the same cycle are allowed at any occupancy. Push into a full queue cannot occur because issue is gated by count < DEPTH.
- inst_valid = !empty && !redirect_valid. inst/inst_pc come from the head register.

## Timing
- Reset values: req_valid 0 while rst is high, state REQ, fetch_pc RESET_PC, queue empty, inst_valid 0, inst 0, inst_pc 0.
- First cycle after rst falls: req_valid=1, req_addr=aligned RESET_PC.
- Latency: rsp_valid in cycle N → inst_valid in N+1.
- Best-case throughput: one instruction per 2 cycles (REQ, WAIT).
- Reset asserted mid-operation clears all state immediately. A response arriving after reset release is not expected; the memory is reset together with this block.
- The output queue fully decouples decoder stalls; memory requests stop once DEPTH entries are held.

## Configuration
- YSYX_22040386_FETCH_PERF_EN defined: adds outputs perf_fetch_cnt[63:0] and perf_stall_cnt[63:0], both reset to 0.
  - perf_fetch_cnt increments on every queue push.
  - perf_stall_cnt increments on every cycle with inst_ready=1 && inst_valid=0.
  - Both wrap at 2^64.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

## Test plan
- Reset then sequential fetch, memory ready always, 1-cycle response: req_addr 0x8000_0000, 0x8000_0000, 0x8000_0008. inst_pc 0x8000_0000, 0x8000_0004, 0x8000_0008. inst takes rsp_data[31:0], then [63:32], then [31:0].
- inst_ready=0 for 20 cycles: exactly DEPTH=4 requests issued, then req_valid=0. Raising inst_ready drains 4 in-order instructions and resumes fetch.
- Redirect to 0x8000_0102 while in WAIT: the pending response is discarded. The next req_addr is 0x8000_0100 and the next inst_pc is 0x8000_0100, with k=0.
- Redirect in the same cycle as a req handshake, with response 3 cycles later: the response is dropped, no inst_valid appears for it, and the next request goes to the redirect target.
- Redirect while the queue is full with inst_ready=1: no pop is counted and inst_valid=0 next cycle. With PERF_EN, perf_fetch_cnt matches the push count and perf_stall_cnt counts the empty cycles.
